// File: rtl/square_voice_mixer_if.sv
// square_voice_mixer_if: audio codec handshake strobes and stereo sample buses
interface square_voice_mixer_if #(parameter int SAMPLE_W = 32);
  logic audio_in_available, audio_out_allowed, read_audio_in, write_audio_out;
  logic signed [SAMPLE_W-1:0] left_channel_audio_in, right_channel_audio_in;
  logic signed [SAMPLE_W-1:0] left_channel_audio_out, right_channel_audio_out;
  modport master(
    input  audio_in_available, audio_out_allowed, left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, write_audio_out, left_channel_audio_out, right_channel_audio_out
  );
  modport slave(
    output audio_in_available, audio_out_allowed, left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, write_audio_out, left_channel_audio_out, right_channel_audio_out
  );
endinterface

// File: rtl/square_voice_mixer.sv
// square_voice_mixer: square-wave voices with sustained/percussive envelopes mixed onto a codec stream
module square_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W = 19,
  parameter int AMP_W = 24,
  parameter int SAMPLE_W = 32,
  parameter int DECAY_SHIFT = 10
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic [NUM_VOICES-1:0] voice_enable,
  input  logic [NUM_VOICES-1:0] voice_mode,
  input  logic [NUM_VOICES-1:0] voice_trigger,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  input  logic [NUM_VOICES*AMP_W-1:0] voice_amp,
  input  logic mix_with_input,
  input  logic clip_clear,
  output logic clip_flag,
  square_voice_mixer_if.master aud
);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  logic [PERIOD_W-1:0] per [NUM_VOICES];
  logic [PERIOD_W-1:0] cnt [NUM_VOICES];
  logic [AMP_W-1:0] amp [NUM_VOICES];
  logic [AMP_W-1:0] env [NUM_VOICES];
  logic [AMP_W-1:0] level [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase;
  logic signed [ACC_W-1:0] sum_reg, sum_nxt;
  logic signed [ACC_W:0] mix_l, mix_r;
  logic ovf_l, ovf_r, xfer;

  assign xfer = aud.audio_in_available & aud.audio_out_allowed;
  assign aud.read_audio_in = xfer;
  assign aud.write_audio_out = xfer;

  always_comb begin
    sum_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      per[i] = voice_period[i*PERIOD_W +: PERIOD_W];
      amp[i] = voice_amp[i*AMP_W +: AMP_W];
      level[i] = voice_enable[i] ? (voice_mode[i] ? env[i] : amp[i]) : '0;
      sum_nxt = phase[i] ? sum_nxt + ACC_W'(level[i]) : sum_nxt - ACC_W'(level[i]);
    end
  end

  // Overflow when the bits above the output sign bit disagree with the true sign
  assign mix_l = (ACC_W+1)'(sum_reg) + (mix_with_input ? (ACC_W+1)'(aud.left_channel_audio_in) : '0);
  assign mix_r = (ACC_W+1)'(sum_reg) + (mix_with_input ? (ACC_W+1)'(aud.right_channel_audio_in) : '0);
  assign ovf_l = mix_l[ACC_W:SAMPLE_W-1] != {(ACC_W-SAMPLE_W+2){mix_l[ACC_W]}};
  assign ovf_r = mix_r[ACC_W:SAMPLE_W-1] != {(ACC_W-SAMPLE_W+2){mix_r[ACC_W]}};
  assign aud.left_channel_audio_out = ovf_l ? {mix_l[ACC_W], {(SAMPLE_W-1){~mix_l[ACC_W]}}} : mix_l[SAMPLE_W-1:0];
  assign aud.right_channel_audio_out = ovf_r ? {mix_r[ACC_W], {(SAMPLE_W-1){~mix_r[ACC_W]}}} : mix_r[SAMPLE_W-1:0];

  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (reset || !voice_enable[i] || per[i] == '0) begin
        cnt[i] <= '0;
        phase[i] <= 1'b0;
      end else if (cnt[i] >= per[i]) begin
        cnt[i] <= '0;
        phase[i] <= ~phase[i];
      end else
        cnt[i] <= cnt[i] + 1'b1;
      if (reset || !voice_enable[i]) env[i] <= '0;
      else if (voice_trigger[i]) env[i] <= amp[i];
      else if (xfer) env[i] <= (env[i] >> DECAY_SHIFT) == '0 ? '0 : env[i] - (env[i] >> DECAY_SHIFT);
    end
    sum_reg <= reset ? '0 : sum_nxt;
    clip_flag <= !reset && ((xfer && (ovf_l || ovf_r)) || (!clip_clear && clip_flag));
  end
endmodule

// File: doc/square_voice_mixer.md
SQUARE_VOICE_MIXER -- requirements
Module: square_voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of square-wave voices (1..8).
REQ-002 Parameter PERIOD_W, default 19: half-period counter width, in CLOCK_50 cycles.
REQ-003 Parameter AMP_W, default 24: unsigned amplitude and envelope width.
REQ-004 Parameter SAMPLE_W, default 32: signed audio sample width.
REQ-005 Parameter DECAY_SHIFT, default 10: envelope decay shift applied per accepted sample.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 Port CLOCK_50, in, 1: sole clock; all state updates on its rising edge.
REQ-008 Port reset, in, 1: synchronous, active-high reset.
REQ-009 Port voice_enable, in, NUM_VOICES: per-voice enable.
REQ-010 Port voice_mode, in, NUM_VOICES: per voice, 0 = sustained, 1 = percussive.
REQ-011 Port voice_trigger, in, NUM_VOICES: one-cycle pulse that starts the percussive envelope.
REQ-012 Port voice_period, in, NUM_VOICES*PERIOD_W: packed half-periods; voice i occupies bits [i*PERIOD_W +: PERIOD_W].
REQ-013 Port voice_amp, in, NUM_VOICES*AMP_W: packed peak amplitudes, packed the same way.
REQ-014 Port mix_with_input, in, 1: when 1, ADC input is added to the voice sum.
REQ-015 Port clip_clear, in, 1: clears clip_flag.
REQ-016 Ports audio_in_available and audio_out_allowed, in, 1 each: audio controller status.
REQ-017 Ports left_channel_audio_in and right_channel_audio_in, in, SAMPLE_W each: signed ADC samples.
REQ-018 Ports read_audio_in and write_audio_out, out, 1 each: audio controller strobes.
REQ-019 Ports left_channel_audio_out and right_channel_audio_out, out, SAMPLE_W each: signed DAC samples.
REQ-020 Port clip_flag, out, 1: sticky saturation indicator.

Function
REQ-021 xfer = audio_in_available & audio_out_allowed; read_audio_in and write_audio_out SHALL both equal xfer, combinationally.
REQ-022 Per-voice counter cnt[i], per cycle:
- If period == 0 or voice disabled: cnt <= 0 and phase <= 0.
- Else if cnt >= period: cnt <= 0 and phase toggles.
- Else: cnt <= cnt + 1.
REQ-023 Output frequency SHALL be 50 MHz / (2*(period+1)). A period reduced below cnt SHALL cause a restart on the next cycle, with no counter wrap-around.
REQ-024 Sustained mode: level[i] = voice_amp[i] while enabled, otherwise 0.
REQ-025 Percussive mode envelope env[i]:
- voice_trigger: env <= voice_amp.
- Else on xfer: env <= env - (env >> DECAY_SHIFT); if (env >> DECAY_SHIFT) == 0, env <= 0.
- Trigger coinciding with xfer: trigger wins.
- Trigger while env != 0: retrigger (reload).
- level[i] = env[i].
REQ-026 Disabling a voice SHALL clear env[i] to 0 on the next cycle.
REQ-027 Contribution c[i] = +level[i] when phase = 1, -level[i] when phase = 0; computed at width SAMPLE_W + clog2(NUM_VOICES) + 1, zero-extended before negation.
REQ-028 sum_reg SHALL register the sum of all c[i] every cycle: 1-cycle latency from level/phase to sum.
REQ-029 Output channel = sat(sum_reg + (mix_with_input ? channel_in : 0)); the adder SHALL be one bit wider than its operands; sat clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; combinational from sum_reg and inputs.
REQ-030 clip_flag SHALL set on a cycle where xfer = 1 and either channel saturates, and clear on clip_clear. If set and clear occur in the same cycle, set wins.
REQ-031 Trigger at cycle t SHALL be visible on the outputs at cycle t+2.

Reset
REQ-032 On reset, the following SHALL be 0 on the next edge: all cnt, phase, env, sum_reg, clip_flag.
REQ-033 While reset is held, audio outputs SHALL be sat(0 + input-if-mixed), and strobes SHALL still follow xfer.
REQ-034 Reset mid-envelope or mid-period SHALL abandon state with no residual output.

Verification
REQ-035 V1: NUM_VOICES=4; voice0 enabled, sustained, period=99, amp=1000, others off, mix=0 -> outputs alternate +1000/-1000 every 100 cycles; first +1000 appears 101 cycles after reset release.
REQ-036 V2: voice1 percussive, amp=2^20, trigger; xfer every 1042 cycles -> env after 1st xfer = 2^20 - 2^10; env decays monotonically to exactly 0 and stays 0.
REQ-037 V3: trigger asserted in the same cycle as xfer -> env equals voice_amp, not decayed.
REQ-038 V4: four voices at amp=2^24-1, same phase=1, mix=1, left_in=2^31-1 -> left out = 2^31-1 and clip_flag=1; clip_clear pulse without xfer -> clip_flag=0.
REQ-039 V5: period changed from 5000 to 10 while cnt=3000 -> cnt resets to 0 next cycle; toggles every 11 cycles thereafter.
REQ-040 V6: reset pulsed during active envelope and toggling -> next cycle sum_reg=0, env=0, cnt=0; out equals left_in when mix=1.
